lfsr_frame_ctrl: RTL
====================

Name: lfsr_frame_ctrl

Overview:
Frame sequencer for the team's 16-bit-per-cycle, 32-bit-state combinational scrambler/CRC step engine. The engine is instantiated beside this block; this block owns the running 32-bit state register. It seeds the state at start-of-frame and advances it once per accepted 16-bit word. It counts frame length, enforces a maximum length, and presents the final state with a valid/ready result handshake.

Parameters:
SEED, 32'hFFFF_FFFF, state loaded into the engine for the first word of every frame
MAX_WORDS, 1024, maximum words per frame (>=1); reaching it without EOF truncates the frame
LEN_W, 11, width of the length counter; must hold MAX_WORDS

Ports:
clk  in  1  clock; all logic rising-edge
rst  in  1  synchronous, active-high reset
s_valid  in  1  input word valid
s_ready  out  1  input word accepted when s_valid & s_ready
s_data  in  16  input word; bit i is the engine's serial bit i (bit 0 stepped first)
s_sof  in  1  word is first of frame
s_eof  in  1  word is last of frame
eng_state  out  32  state presented to engine data_load
eng_din  out  16  word presented to engine serial_in (= s_data, unregistered)
eng_next  in  32  engine data_out (16 steps applied)
res_valid  out  1  result available
res_ready  in  1  result consumed when res_valid & res_ready
res_crc  out  32  final frame state
res_len  out  LEN_W  words in frame
res_trunc  out  1  frame closed by MAX_WORDS, not EOF
err_nosof  out  1  one-cycle pulse: word dropped in IDLE without SOF
err_restart  out  1  one-cycle pulse: SOF received mid-frame
busy  out  1  high in RUN or DONE

Behaviour:
- Reset: state IDLE, crc_reg=SEED, count=0. All result and error outputs 0. busy=0.
- eng_state is combinational: SEED in IDLE or on any accepted SOF word; crc_reg otherwise.
- FSM IDLE -> RUN -> DONE -> IDLE. Each accepted word costs one cycle; throughput 1 word/clk.
- IDLE: s_ready=1.
  - Accepted word with s_sof=0: dropped; err_nosof pulses next cycle.
  - Accepted word with s_sof=1: crc_reg<=eng_next, count<=1. Goes to DONE if s_eof or MAX_WORDS==1, else RUN.
- RUN: s_ready=1.
  - Accepted non-SOF word: crc_reg<=eng_next, count<=count+1.
  - Accepted SOF word: frame restarts with crc_reg<=eng_next from SEED, count<=1, err_restart pulses.
  - Accepted word with s_eof, or whose count+1==MAX_WORDS: go to DONE. res_trunc=1 only if s_eof=0.
- DONE: s_ready=0, res_valid=1. res_crc, res_len and res_trunc are registered and stable while res_valid is high. On res_ready, return to IDLE the next cycle, res_valid<=0, crc_reg<=SEED.
- Result latency: res_valid rises the cycle after the EOF word is accepted.
- A new frame's SOF is accepted no earlier than the cycle after the handshake; there is no bubble beyond that.
- rst mid-frame or in DONE: frame discarded, no result emitted, return to IDLE.
- s_sof and s_eof are ignored when s_valid=0. s_eof on the same word as SOF forms a 1-word frame.

Optional Feature:
FINAL_XOR_EN: when defined, res_crc = crc_reg ^ 32'hFFFF_FFFF. When undefined, res_crc = crc_reg unmodified. Length, trunc and handshake behaviour are identical in both builds.

Test Plan:
- SEED=0; frame of 3 words 0x0000 (SOF on 1st, EOF on 3rd) -> res_crc=0x0000_0000, res_len=3, res_trunc=0. With FINAL_XOR_EN -> 0xFFFF_FFFF.
- SEED=0; single word 0x0001 with SOF+EOF -> res_valid next cycle, res_crc=0x0000_8000, res_len=1. Word 0x8000 -> res_crc=0x0000_0001.
- Hold res_ready=0 for 5 cycles in DONE -> s_ready=0, outputs stable. res_ready=1 -> IDLE next cycle, a SOF word accepted the cycle after.
- Word without SOF in IDLE -> err_nosof 1-cycle pulse, no state change. SOF mid-frame after 4 words -> err_restart pulse, final res_len counts from the restart.
- MAX_WORDS=4; 6 words with no EOF -> DONE after 4th, res_len=4, res_trunc=1. The 5th word is stalled (s_ready=0).
- Assert rst for 1 cycle after 2 words of a frame -> busy=0, no res_valid. Next frame result matches a fresh-SEED bench model.

Source files
------------

// File: rtl/lfsr_frame_ctrl.sv
// Frame sequencer that owns the running 32-bit state of a 16-bit-per-cycle scrambler/CRC step engine.
// Optional build macro FINAL_XOR_EN: when defined, the reported result is the final state inverted.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for an SOF word; non-SOF words are dropped
// ST_RUN  | frame open, state advanced once per accepted word
// ST_DONE | result held on res_*, input stalled until res_ready
module lfsr_frame_ctrl #(
    parameter logic [31:0] SEED      = 32'hFFFF_FFFF,
    parameter int          MAX_WORDS = 1024,
    parameter int          LEN_W     = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [15:0]      s_data,
    input  logic             s_sof,
    input  logic             s_eof,
    output logic [31:0]      eng_state,
    output logic [15:0]      eng_din,
    input  logic [31:0]      eng_next,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_crc,
    output logic [LEN_W-1:0] res_len,
    output logic             res_trunc,
    output logic             err_nosof,
    output logic             err_restart,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [31:0]      r_crc;
    logic [LEN_W-1:0] r_count;
    logic             r_s_ready;
    logic             r_busy;
    logic             r_res_valid;
    logic [31:0]      r_res_crc;
    logic [LEN_W-1:0] r_res_len;
    logic             r_res_trunc;
    logic             r_err_nosof;
    logic             r_err_restart;

    logic             w_acc;
    logic             w_start;
    logic [LEN_W-1:0] w_cnt_nxt;
    logic             w_close;
    logic [31:0]      w_final;

    assign w_acc     = s_valid & r_s_ready;
    assign w_start   = w_acc & s_sof;
    assign w_cnt_nxt = w_start ? LEN_W'(1) : r_count + LEN_W'(1);
    assign w_close   = s_eof | (w_cnt_nxt == LEN_W'(MAX_WORDS));

    // An SOF word always restarts from SEED, even mid-frame.
    assign eng_state = ((r_state == ST_IDLE) || w_start) ? SEED : r_crc;
    assign eng_din   = s_data;

`ifdef FINAL_XOR_EN
    assign w_final = eng_next ^ 32'hFFFF_FFFF;
`else
    assign w_final = eng_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_crc         <= SEED;
            r_count       <= '0;
            r_s_ready     <= 1'b1;
            r_busy        <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_crc     <= '0;
            r_res_len     <= '0;
            r_res_trunc   <= 1'b0;
            r_err_nosof   <= 1'b0;
            r_err_restart <= 1'b0;
        end else begin
            r_err_nosof   <= 1'b0;
            r_err_restart <= 1'b0;
            case (r_state)
                ST_IDLE, ST_RUN: begin
                    if (w_acc) begin
                        if ((r_state == ST_IDLE) && !s_sof) begin
                            r_err_nosof <= 1'b1;
                        end else begin
                            r_crc         <= eng_next;
                            r_count       <= w_cnt_nxt;
                            r_err_restart <= (r_state == ST_RUN) & s_sof;
                            r_busy        <= 1'b1;
                            if (w_close) begin
                                r_state     <= ST_DONE;
                                r_s_ready   <= 1'b0;
                                r_res_valid <= 1'b1;
                                r_res_crc   <= w_final;
                                r_res_len   <= w_cnt_nxt;
                                r_res_trunc <= ~s_eof;
                            end else begin
                                r_state <= ST_RUN;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        r_state     <= ST_IDLE;
                        r_res_valid <= 1'b0;
                        r_s_ready   <= 1'b1;
                        r_busy      <= 1'b0;
                        r_crc       <= SEED;
                        r_count     <= '0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_s_ready <= 1'b1;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready     = r_s_ready;
    assign busy        = r_busy;
    assign res_valid   = r_res_valid;
    assign res_crc     = r_res_crc;
    assign res_len     = r_res_len;
    assign res_trunc   = r_res_trunc;
    assign err_nosof   = r_err_nosof;
    assign err_restart = r_err_restart;

endmodule
